// File: rtl/piso_shift_ctrl_if.sv
// Upstream word handshake into piso_shift_ctrl. A word transfers on a posedge
// where in_valid && in_ready; the source holds in_data/in_valid until then.
interface piso_shift_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/piso_shift_ctrl.sv
// Sequencer for a WIDTH-bit PISO: accepts a word, strobes load, paces shifting
// on tick, flags bit validity and frame edges, then inserts an idle gap.
module piso_shift_ctrl #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 3
) (
  input  logic             clk,
  input  logic             res,
  piso_shift_ctrl_if.slave up,
  input  logic             tick,
  input  logic             flush,
  output logic [WIDTH-1:0] d,
  output logic             load,
  output logic             shift_en,
  output logic             bit_valid,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             frame_start,
  output logic             frame_end,
  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [WIDTH-1:0]   d_q, d_d;
  logic               load_q, load_d;
  logic               bit_valid_q, bit_valid_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               frame_start_q, frame_start_d;
  logic               busy_q, busy_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               last_bit;

  assign last_bit = (bit_cnt_q == CNT_W'(WIDTH - 1));

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q       <= IDLE;
      in_ready_q    <= 1'b0;
      d_q           <= '0;
      load_q        <= 1'b0;
      bit_valid_q   <= 1'b0;
      bit_cnt_q     <= '0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      gap_q         <= '0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      d_q           <= d_d;
      load_q        <= load_d;
      bit_valid_q   <= bit_valid_d;
      bit_cnt_q     <= bit_cnt_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      gap_q         <= gap_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    d_d           = d_q;
    load_d        = 1'b0;
    bit_valid_d   = bit_valid_q;
    bit_cnt_d     = bit_cnt_q;
    frame_start_d = 1'b0;
    busy_d        = busy_q;
    gap_d         = gap_q;
    shift_en      = 1'b0;
    frame_end     = 1'b0;

    // flush outranks everything, including an accept in IDLE
    if (flush) begin
      state_d     = IDLE;
      in_ready_d  = 1'b1;
      bit_valid_d = 1'b0;
      bit_cnt_d   = '0;
      busy_d      = 1'b0;
      gap_d       = '0;
    end else begin
      case (state_q)
        IDLE: begin
          in_ready_d = 1'b1;
          if (up.in_valid && in_ready_q) begin
            d_d        = up.in_data;
            load_d     = 1'b1;
            in_ready_d = 1'b0;
            busy_d     = 1'b1;
            state_d    = LOAD;
          end
        end
        LOAD: begin
          state_d       = SHIFT;
          bit_valid_d   = 1'b1;
          bit_cnt_d     = '0;
          frame_start_d = 1'b1;
        end
        SHIFT: begin
          if (tick) begin
            if (!last_bit) begin
              shift_en  = 1'b1;
              bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end else begin
              frame_end   = 1'b1;
              bit_valid_d = 1'b0;
              bit_cnt_d   = '0;
              gap_d       = '0;
              if (GAP_CYCLES == 0) begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
                busy_d     = 1'b0;
              end else begin
                state_d = GAP;
              end
            end
          end
        end
        GAP: begin
          // in_ready is raised on the exit edge so it is already 1 in the first IDLE cycle
          if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
            state_d    = IDLE;
            in_ready_d = 1'b1;
            busy_d     = 1'b0;
            gap_d      = '0;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign up.in_ready   = in_ready_q;
  assign d             = d_q;
  assign load          = load_q;
  assign bit_valid     = bit_valid_q;
  assign bit_cnt       = bit_cnt_q;
  assign frame_start   = frame_start_q;
  assign busy          = busy_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_piso_shift_ctrl.sv
// Directed bench for piso_shift_ctrl (WIDTH=4, GAP_CYCLES=2). Output snapshot
// is {in_ready, load, shift_en, bit_valid, bit_cnt[2:0], frame_start, frame_end, busy}.
module tb_piso_shift_ctrl;

  logic       clk;
  logic       res;
  logic       tick;
  logic       flush;
  logic [3:0] d;
  logic       load;
  logic       shift_en;
  logic       bit_valid;
  logic [2:0] bit_cnt;
  logic       frame_start;
  logic       frame_end;
  logic       busy;
  logic [1:0] state_dbg;
  logic [9:0] obs;

  int vec_cnt = 0;
  int err_cnt = 0;

  piso_shift_ctrl_if #(.WIDTH(4)) up_if ();

  piso_shift_ctrl #(
    .WIDTH(4), .GAP_CYCLES(2), .CNT_W(3)
  ) dut (
    .clk(clk), .res(res), .up(up_if), .tick(tick), .flush(flush),
    .d(d), .load(load), .shift_en(shift_en), .bit_valid(bit_valid),
    .bit_cnt(bit_cnt), .frame_start(frame_start), .frame_end(frame_end),
    .busy(busy), .state_dbg(state_dbg)
  );

  assign obs = {up_if.in_ready, load, shift_en, bit_valid, bit_cnt,
                frame_start, frame_end, busy};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    res = 1'b0;
    up_if.in_valid = 1'b1;
    up_if.in_data  = 4'b1111;
    tick  = 1'b1;
    flush = 1'b0;
    #12;
    vec_cnt++;
    if (obs !== 10'b0 || d !== 4'b0 || state_dbg !== 2'd0) begin
      err_cnt++;
      $display("FAIL reset_hold: got obs=%b d=%b st=%0d expected all 0", obs, d, state_dbg);
    end
    @(negedge clk);
    res = 1'b1;
    #1;
    vec_cnt++;
    if (obs !== 10'b0) begin
      err_cnt++;
      $display("FAIL reset_release: got %b expected %b", obs, 10'b0);
    end
    @(negedge clk);
    up_if.in_valid = 1'b0;
    #1;
    vec_cnt++;
    if (obs !== 10'b1_0_0_0_000_0_0_0 || d !== 4'b0) begin
      err_cnt++;
      $display("FAIL reset_ready: got obs=%b d=%b expected 1000000000 d=0000", obs, d);
    end
  endtask

  task automatic test_single_frame();
    logic [9:0] exp_o [9] = '{
      10'b1_0_0_0_000_0_0_0, 10'b0_1_0_0_000_0_0_1, 10'b0_0_1_1_000_1_0_1,
      10'b0_0_1_1_001_0_0_1, 10'b0_0_1_1_010_0_0_1, 10'b0_0_0_1_011_0_1_1,
      10'b0_0_0_0_000_0_0_1, 10'b0_0_0_0_000_0_0_1, 10'b1_0_0_0_000_0_0_0};
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      up_if.in_valid = (i == 0);
      up_if.in_data  = 4'b1001;
      tick  = 1'b1;
      flush = 1'b0;
      #1;
      vec_cnt++;
      if (obs !== exp_o[i]) begin
        err_cnt++;
        $display("FAIL single cycle %0d: got %b expected %b", i, obs, exp_o[i]);
      end
      if (i == 1) begin
        vec_cnt++;
        if (d !== 4'b1001) begin
          err_cnt++;
          $display("FAIL single_d: got %b expected 1001", d);
        end
      end
    end
  endtask

  task automatic test_paced();
    logic [9:0] exp_o [17] = '{
      10'b1_0_0_0_000_0_0_0, 10'b0_1_0_0_000_0_0_1, 10'b0_0_0_1_000_1_0_1,
      10'b0_0_0_1_000_0_0_1, 10'b0_0_1_1_000_0_0_1, 10'b0_0_0_1_001_0_0_1,
      10'b0_0_0_1_001_0_0_1, 10'b0_0_1_1_001_0_0_1, 10'b0_0_0_1_010_0_0_1,
      10'b0_0_0_1_010_0_0_1, 10'b0_0_1_1_010_0_0_1, 10'b0_0_0_1_011_0_0_1,
      10'b0_0_0_1_011_0_0_1, 10'b0_0_0_1_011_0_1_1, 10'b0_0_0_0_000_0_0_1,
      10'b0_0_0_0_000_0_0_1, 10'b1_0_0_0_000_0_0_0};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      up_if.in_valid = (i == 0);
      up_if.in_data  = 4'b1010;
      tick  = (i >= 2) && (((i - 2) % 3) == 2);
      flush = 1'b0;
      #1;
      vec_cnt++;
      if (obs !== exp_o[i]) begin
        err_cnt++;
        $display("FAIL paced cycle %0d: got %b expected %b", i, obs, exp_o[i]);
      end
      if (i == 1) begin
        vec_cnt++;
        if (d !== 4'b1010) begin
          err_cnt++;
          $display("FAIL paced_d: got %b expected 1010", d);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] exp_o [17] = '{
      10'b1_0_0_0_000_0_0_0, 10'b0_1_0_0_000_0_0_1, 10'b0_0_1_1_000_1_0_1,
      10'b0_0_1_1_001_0_0_1, 10'b0_0_1_1_010_0_0_1, 10'b0_0_0_1_011_0_1_1,
      10'b0_0_0_0_000_0_0_1, 10'b0_0_0_0_000_0_0_1, 10'b1_0_0_0_000_0_0_0,
      10'b0_1_0_0_000_0_0_1, 10'b0_0_1_1_000_1_0_1, 10'b0_0_1_1_001_0_0_1,
      10'b0_0_1_1_010_0_0_1, 10'b0_0_0_1_011_0_1_1, 10'b0_0_0_0_000_0_0_1,
      10'b0_0_0_0_000_0_0_1, 10'b1_0_0_0_000_0_0_0};
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      up_if.in_valid = (i <= 8);
      up_if.in_data  = (i == 0) ? 4'b1010 : 4'b0110;
      tick  = 1'b1;
      flush = 1'b0;
      #1;
      vec_cnt++;
      if (obs !== exp_o[i]) begin
        err_cnt++;
        $display("FAIL b2b cycle %0d: got %b expected %b", i, obs, exp_o[i]);
      end
      if (i == 1 || i == 8) begin
        vec_cnt++;
        if (d !== 4'b1010) begin
          err_cnt++;
          $display("FAIL b2b_d1 cycle %0d: got %b expected 1010", i, d);
        end
      end
      if (i == 9 || i == 16) begin
        vec_cnt++;
        if (d !== 4'b0110) begin
          err_cnt++;
          $display("FAIL b2b_d2 cycle %0d: got %b expected 0110", i, d);
        end
      end
    end
  endtask

  task automatic test_flush();
    logic [9:0] exp_o [13] = '{
      10'b1_0_0_0_000_0_0_0, 10'b0_1_0_0_000_0_0_1, 10'b0_0_1_1_000_1_0_1,
      10'b0_0_0_1_001_0_0_1, 10'b1_0_0_0_000_0_0_0, 10'b0_1_0_0_000_0_0_1,
      10'b0_0_1_1_000_1_0_1, 10'b0_0_1_1_001_0_0_1, 10'b0_0_1_1_010_0_0_1,
      10'b0_0_0_1_011_0_1_1, 10'b0_0_0_0_000_0_0_1, 10'b0_0_0_0_000_0_0_1,
      10'b1_0_0_0_000_0_0_0};
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      up_if.in_valid = (i == 0) || (i == 4);
      up_if.in_data  = 4'b1001;
      tick  = 1'b1;
      flush = (i == 3);
      #1;
      vec_cnt++;
      if (obs !== exp_o[i]) begin
        err_cnt++;
        $display("FAIL flush cycle %0d: got %b expected %b", i, obs, exp_o[i]);
      end
    end
    // flush in IDLE alongside a valid word: the word must not be taken
    @(negedge clk);
    up_if.in_valid = 1'b1;
    up_if.in_data  = 4'b0101;
    flush = 1'b1;
    @(negedge clk);
    up_if.in_valid = 1'b0;
    flush = 1'b0;
    #1;
    vec_cnt++;
    if (obs !== 10'b1_0_0_0_000_0_0_0 || d !== 4'b1001) begin
      err_cnt++;
      $display("FAIL flush_accept: got obs=%b d=%b expected 1000000000 d=1001", obs, d);
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] pre_o [4] = '{
      10'b1_0_0_0_000_0_0_0, 10'b0_1_0_0_000_0_0_1,
      10'b0_0_1_1_000_1_0_1, 10'b0_0_1_1_001_0_0_1};
    logic [9:0] post_o [9] = '{
      10'b1_0_0_0_000_0_0_0, 10'b0_1_0_0_000_0_0_1, 10'b0_0_1_1_000_1_0_1,
      10'b0_0_1_1_001_0_0_1, 10'b0_0_1_1_010_0_0_1, 10'b0_0_0_1_011_0_1_1,
      10'b0_0_0_0_000_0_0_1, 10'b0_0_0_0_000_0_0_1, 10'b1_0_0_0_000_0_0_0};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      up_if.in_valid = (i == 0);
      up_if.in_data  = 4'b0110;
      tick  = 1'b1;
      flush = 1'b0;
      #1;
      vec_cnt++;
      if (obs !== pre_o[i]) begin
        err_cnt++;
        $display("FAIL arst_pre cycle %0d: got %b expected %b", i, obs, pre_o[i]);
      end
    end
    #1;
    res = 1'b0;
    #1;
    vec_cnt++;
    if (obs !== 10'b0 || d !== 4'b0 || state_dbg !== 2'd0) begin
      err_cnt++;
      $display("FAIL arst_clear: got obs=%b d=%b st=%0d expected all 0", obs, d, state_dbg);
    end
    @(negedge clk);
    res = 1'b1;
    #1;
    vec_cnt++;
    if (obs !== 10'b0) begin
      err_cnt++;
      $display("FAIL arst_release: got %b expected %b", obs, 10'b0);
    end
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      up_if.in_valid = (i == 0);
      up_if.in_data  = 4'b1001;
      tick  = 1'b1;
      flush = 1'b0;
      #1;
      vec_cnt++;
      if (obs !== post_o[i]) begin
        err_cnt++;
        $display("FAIL arst_post cycle %0d: got %b expected %b", i, obs, post_o[i]);
      end
      if (i == 1) begin
        vec_cnt++;
        if (d !== 4'b1001) begin
          err_cnt++;
          $display("FAIL arst_d: got %b expected 1001", d);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_paced();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
